// File: rtl/max_pool_2x2_stream.sv
// ---------------------------------------------------------------------------
// max_pool_2x2_stream
//
// Streaming 2x2 / stride-2 max-pooling stage for a single feature-map channel.
// Pixels arrive in raster order over a valid/ready handshake. On even rows the
// horizontal maximum of each column pair is parked in a line buffer. On odd rows
// the bottom pair maximum is compared with the parked top maximum, and one pooled
// pixel per 2x2 window is emitted through a single-stage output register.
//
// Optional feature: define MAXPOOL_ARGMAX_EN to add the out_idx port, which
// carries the winner position (0=TL, 1=TR, 2=BL, 3=BR). The line buffer then
// stores DATA_W+2 bits per entry instead of DATA_W.
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-high reset
//   cfg_width   frame width in pixels (even, 2..MAX_W), sampled on first pixel
//   in_valid    input pixel valid
//   in_ready    input pixel accepted when in_valid & in_ready
//   in_data     input pixel (unsigned)
//   in_last     final pixel of the frame
//   out_valid   pooled pixel valid
//   out_ready   downstream accept
//   out_data    pooled pixel (max of the 2x2 window)
//   out_idx     winner position (only with MAXPOOL_ARGMAX_EN)
//   frame_done  1-cycle pulse, frame ended at the correct position
//   frame_err   1-cycle pulse, in_last arrived at an illegal position
// ---------------------------------------------------------------------------
module max_pool_2x2_stream #(
   parameter int DATA_W = 8,
   parameter int MAX_W  = 64,
   parameter int CNT_W  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  cfg_width,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
`ifdef MAXPOOL_ARGMAX_EN
   output logic [1:0]        out_idx,
`endif
   output logic              frame_done,
   output logic              frame_err
);

   localparam int LB_D  = MAX_W / 2;
   localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
`ifdef MAXPOOL_ARGMAX_EN
   localparam int LB_W  = DATA_W + 2;
`else
   localparam int LB_W  = DATA_W;
`endif

   typedef enum logic {ROW_EVEN = 1'b0, ROW_ODD = 1'b1} row_t;

   row_t              state;
   logic [CNT_W-1:0]  col;
   logic [CNT_W-1:0]  width_q;
   logic              active;
   logic [DATA_W-1:0] pair_q;

   logic [LB_W-1:0]   lbuf [LB_D];
   logic [LB_W-1:0]   lb_rd;
   logic [LB_W-1:0]   lb_wr;
   logic [LB_AW-1:0]  lb_addr;

   logic [CNT_W-1:0]  w_eff;
   logic              xfer;
   logic              at_end;
   logic              odd_col;
   logic              legal_last;
   logic              emit;

   logic              h_right;
   logic [DATA_W-1:0] h_max;
   logic [DATA_W-1:0] top_data;
   logic              bot_win;
   logic [DATA_W-1:0] win_data;
`ifdef MAXPOOL_ARGMAX_EN
   logic [1:0]        win_idx;
`endif

   assign in_ready = !out_valid | out_ready;
   assign xfer     = in_valid & in_ready;

   // The width latch is only trusted once a frame has started; the very first
   // pixel of a frame must already use the live cfg_width.
   assign w_eff      = active ? width_q : cfg_width;
   assign at_end     = (col == (w_eff - CNT_W'(1)));
   assign odd_col    = col[0];
   assign legal_last = (state == ROW_ODD) && at_end;
   assign lb_addr    = col[LB_AW:1];
   assign lb_rd      = lbuf[lb_addr];

   // An illegal in_last on the bottom-right pixel discards that window.
   assign emit = xfer && (state == ROW_ODD) && odd_col && (!in_last || legal_last);

   // Strict greater-than keeps the earlier position on ties, which gives the
   // TL > TR > BL > BR priority: left beats right, top beats bottom.
   always_comb begin
      h_right  = in_data > pair_q;
      h_max    = h_right ? in_data : pair_q;
      top_data = lb_rd[DATA_W-1:0];
      bot_win  = h_max > top_data;
      win_data = bot_win ? h_max : top_data;
   end

`ifdef MAXPOOL_ARGMAX_EN
   assign lb_wr   = {1'b0, h_right, h_max};
   assign win_idx = bot_win ? {1'b1, h_right} : lb_rd[DATA_W+1:DATA_W];
`else
   assign lb_wr   = h_max;
`endif

   // Line buffer holds top-row pair maxima; contents need no reset.
   always_ff @(posedge clk) begin
      if (xfer && (state == ROW_EVEN) && odd_col && !in_last) begin
         lbuf[lb_addr] <= lb_wr;
      end
   end

   // Row FSM, column counter, pair register and the registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ROW_EVEN;
         col        <= '0;
         width_q    <= '0;
         active     <= 1'b0;
         pair_q     <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
`ifdef MAXPOOL_ARGMAX_EN
         out_idx    <= 2'd0;
`endif
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (xfer) begin
            if (!odd_col) begin
               pair_q <= in_data;
            end
            if (!active) begin
               width_q <= cfg_width;
            end

            if (in_last) begin
               state  <= ROW_EVEN;
               col    <= '0;
               active <= 1'b0;
               if (legal_last) begin
                  frame_done <= 1'b1;
               end else begin
                  frame_err  <= 1'b1;
               end
            end else begin
               active <= 1'b1;
               if (at_end) begin
                  col   <= '0;
                  state <= (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
               end else begin
                  col   <= col + CNT_W'(1);
               end
            end

            // Loading here overrides the clear above, so a full register that
            // drains in the same cycle is refilled without a bubble.
            if (emit) begin
               out_valid <= 1'b1;
               out_data  <= win_data;
`ifdef MAXPOOL_ARGMAX_EN
               out_idx   <= win_idx;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// ---------------------------------------------------------------------------
// tb_max_pool_2x2_stream
//
// Self-checking bench for max_pool_2x2_stream. A window-level reference model
// turns each stimulus frame into the list of pooled pixels it must produce;
// a monitor compares every accepted output against that list. Directed frames
// cover the basic pooling, ties, back-pressure, illegal in_last, asynchronous
// reset and random back-to-back full-width frames.
// Define MAXPOOL_ARGMAX_EN to also compare the winner index.
// ---------------------------------------------------------------------------
module tb_max_pool_2x2_stream;

   localparam int DW = 8;
   localparam int MW = 64;
   localparam int CW = 7;

   typedef struct {
      logic [DW-1:0] d;
      logic [1:0]    idx;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [CW-1:0] cfg_width;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
`ifdef MAXPOOL_ARGMAX_EN
   logic [1:0]    out_idx;
`endif
   logic          frame_done;
   logic          frame_err;

   int checks = 0;
   int errors = 0;

   exp_t          expQ[$];
   exp_t          modelQ[$];
   logic [DW-1:0] framePix [1024];

   int doneCnt = 0;
   int errCnt  = 0;
   int expDone = 0;
   int expErr  = 0;
   int rdyMode = 0;
   int stallArm = 0;
   int stallCnt = 0;
   bit holdValid = 0;
   logic [DW-1:0] holdData = '0;

   max_pool_2x2_stream #(.DATA_W(DW), .MAX_W(MW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_width  (cfg_width),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
`ifdef MAXPOOL_ARGMAX_EN
      .out_idx    (out_idx),
`endif
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Reference: every 2x2 window whose bottom-right pixel was accepted
   // (and was not an illegal last pixel) yields max and first position of max.
   function automatic void modelFrame(input int w, input int n, input bit errFrame);
      logic [DW-1:0] v [4];
      logic [DW-1:0] m;
      logic [1:0]    k;
      int br;
      exp_t e;
      modelQ.delete();
      for (int r = 1; r * w < n; r += 2) begin
         for (int c = 1; c < w; c += 2) begin
            br = r * w + c;
            if (br < n && !(errFrame && br == n - 1)) begin
               v[0] = framePix[(r - 1) * w + c - 1];
               v[1] = framePix[(r - 1) * w + c];
               v[2] = framePix[r * w + c - 1];
               v[3] = framePix[br];
               m = v[0];
               k = 2'd0;
               for (int j = 1; j < 4; j++) begin
                  if (v[j] > m) begin
                     m = v[j];
                     k = 2'(j);
                  end
               end
               e.d = m;
               e.idx = k;
               modelQ.push_back(e);
            end
         end
      end
   endfunction

   task automatic sendPixel(input logic [DW-1:0] d, input bit last);
      int t;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      t = 0;
      while (1) begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready 0 for %0d cycles, required 1", t);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic applyStimulus(input int w, input int n, input bit randGap, input bit scramble);
      bit errFrame;
      errFrame = !((((n - 1) / w) % 2 == 1) && ((n - 1) % w == w - 1));
      modelFrame(w, n, errFrame);
      foreach (modelQ[i]) expQ.push_back(modelQ[i]);
      cfg_width = CW'(w);
      for (int i = 0; i < n; i++) begin
         if (randGap && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         sendPixel(framePix[i], i == n - 1);
         if (scramble && i == 0) cfg_width = CW'($urandom_range(2, MW));
      end
      checkOutput("frame_done_pulse", frame_done, !errFrame);
      checkOutput("frame_err_pulse", frame_err, errFrame);
      if (errFrame) expErr++;
      else expDone++;
   endtask

   task automatic waitDrain();
      int t;
      t = 0;
      while (expQ.size() > 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      checkOutput("drain_pending", expQ.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic loadFrame(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d);
      framePix[0] = a;
      framePix[1] = b;
      framePix[2] = c;
      framePix[3] = d;
      if (n > 4) $display("[TB] loadFrame only sets four pixels");
   endtask

   // Downstream ready driver, with an optional 3-cycle stall on the first output.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stallArm != 0 && out_valid) begin
            stallArm = 0;
            stallCnt = 3;
         end
         if (stallCnt > 0) begin
            out_ready = 1'b0;
            stallCnt--;
         end else begin
            case (rdyMode)
               0:       out_ready = 1'b1;
               1:       out_ready = 1'($urandom_range(0, 1));
               default: out_ready = 1'b0;
            endcase
         end
      end
   end

   // Output monitor: scoreboard compare, stability under back-pressure, in_ready rule.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (out_valid) begin
               if (holdValid) checkOutput("hold_data", out_data, holdData);
               if (!out_ready) begin
                  checkOutput("in_ready_stall", in_ready, 0);
                  holdValid = 1'b1;
                  holdData  = out_data;
               end else begin
                  holdValid = 1'b0;
                  if (expQ.size() == 0) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL unexpected_output: got data %0d, required none", out_data);
                  end else begin
                     e = expQ.pop_front();
                     checkOutput("out_data", out_data, e.d);
`ifdef MAXPOOL_ARGMAX_EN
                     checkOutput("out_idx", out_idx, e.idx);
`endif
                  end
               end
            end else begin
               holdValid = 1'b0;
               checkOutput("in_ready_idle", in_ready, 1);
            end
            if (frame_done) doneCnt++;
            if (frame_err) errCnt++;
         end else begin
            holdValid = 1'b0;
         end
      end
   end

   initial begin
      rst       = 1'b1;
      cfg_width = CW'(4);
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      #1;
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_data", out_data, 0);
      checkOutput("reset_frame_done", frame_done, 0);
      checkOutput("reset_frame_err", frame_err, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // T1: 4x4 ramp, always ready
      $display("[TB] T1 4x4 ramp");
      for (int i = 0; i < 16; i++) framePix[i] = DW'(i + 1);
      applyStimulus(4, 16, 0, 0);
      checkOutput("model_t1_n", modelQ.size(), 4);
      checkOutput("model_t1_0", modelQ[0].d, 6);
      checkOutput("model_t1_1", modelQ[1].d, 8);
      checkOutput("model_t1_2", modelQ[2].d, 14);
      checkOutput("model_t1_3", modelQ[3].d, 16);
      checkOutput("model_t1_idx", modelQ[3].idx, 3);
      waitDrain();

      // T2: all-equal 2x2 window
      $display("[TB] T2 tie 2x2");
      loadFrame(4, 7, 7, 7, 7);
      applyStimulus(2, 4, 0, 0);
      checkOutput("model_t2_d", modelQ[0].d, 7);
      checkOutput("model_t2_idx", modelQ[0].idx, 0);
      waitDrain();

      // T3: T1 data with a 3-cycle stall on the first output
      $display("[TB] T3 back-pressure");
      for (int i = 0; i < 16; i++) framePix[i] = DW'(i + 1);
      stallArm = 1;
      applyStimulus(4, 16, 0, 0);
      waitDrain();

      // T4: illegal in_last, then a clean 2x2 frame
      $display("[TB] T4 early in_last");
      loadFrame(4, 1, 2, 3, 0);
      applyStimulus(4, 3, 0, 0);
      checkOutput("model_t4_none", modelQ.size(), 0);
      loadFrame(4, 0, 9, 3, 1);
      applyStimulus(2, 4, 0, 0);
      checkOutput("model_t4_d", modelQ[0].d, 9);
      checkOutput("model_t4_idx", modelQ[0].idx, 1);
      waitDrain();

      // T5: async reset with an output pending in ROW_ODD
      $display("[TB] T5 async reset");
      rdyMode = 2;
      cfg_width = CW'(4);
      for (int i = 0; i < 6; i++) sendPixel(DW'(i + 1), 1'b0);
      checkOutput("t5_pending_valid", out_valid, 1);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("t5_async_out_valid", out_valid, 0);
      checkOutput("t5_async_out_data", out_data, 0);
      @(negedge clk);
      rst = 1'b0;
      rdyMode = 0;
      @(posedge clk);
      #1;
      loadFrame(4, 4, 2, 8, 1);
      applyStimulus(2, 4, 0, 0);
      checkOutput("model_t5_d", modelQ[0].d, 8);
      checkOutput("model_t5_idx", modelQ[0].idx, 2);
      waitDrain();

      // T6: two back-to-back full-width random frames, random gaps and ready
      $display("[TB] T6 random full width");
      rdyMode = 1;
      for (int i = 0; i < 4 * MW; i++) framePix[i] = DW'($urandom_range(0, 255));
      applyStimulus(MW, 4 * MW, 1, 1);
      for (int i = 0; i < 4 * MW; i++) framePix[i] = DW'($urandom_range(0, 3));
      applyStimulus(MW, 4 * MW, 1, 1);
      waitDrain();
      rdyMode = 0;
      repeat (3) @(posedge clk);
      #1;

      checkOutput("frame_done_count", doneCnt, expDone);
      checkOutput("frame_err_count", errCnt, expErr);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
